iq_frame_buffer: RTL and testbench
==================================

// Module: iq_frame_buffer
// PURPOSE
//  Buffers 32-bit I/Q pairs from the demodulator (WRITE, RE_IN, IM_IN) and serves them
//  as 16-bit words to the SPI communication layer (READ = word-done strobe, DOUT).
//  Raises READY2READ once a full frame of pairs is stored, so the host reads whole frames.
//  Sits between Demodulate and CommunicationLayer; replaces the current storage path.
// PARAMETERS
//  DEPTH_PAIRS  256  pair capacity (power of 2); memory is 64 bits x DEPTH_PAIRS
//  FRAME_PAIRS  64   pairs per host frame; 1 <= FRAME_PAIRS <= DEPTH_PAIRS
//  WORD_W       16   output word width (= `RegBusWidth)
// PORTS
//  coreClock   in   1                        64 MHz core clock; all logic on rising edge
//  ENABLE      in   1                        async reset, active-low (low = reset)
//  WRITE       in   1                        1-cycle pulse, coreClock domain: push {RE_IN,IM_IN}
//  RE_IN       in   32                       in-phase sample, two's complement
//  IM_IN       in   32                       quadrature sample, two's complement
//  READ        in   1                        SPI word-done level/pulse, async to coreClock
//  CLEAR       in   1                        sync flush (from MemoryMap on RUN rising edge)
//  DOUT        out  WORD_W                   current word to SPI shifter
//  READY2READ  out  1                        frame available / frame readout in progress
//  FULL        out  1                        fill == DEPTH_PAIRS
//  EMPTY       out  1                        fill == 0
//  OVERFLOW    out  1                        sticky: a WRITE was dropped
//  FILL        out  $clog2(DEPTH_PAIRS)+1    stored pairs, counting the pair being read out
// BEHAVIOUR
//  Reset (ENABLE=0, async): pointers, word index, FILL=0; DOUT=0, READY2READ=0, FULL=0,
//   EMPTY=1, OVERFLOW=0, FSM=IDLE, sync flops=0. Output state in effect the cycle ENABLE is low.
//  Write: WRITE & !FULL -> mem[wptr]={RE_IN,IM_IN}; wptr+1 mod DEPTH_PAIRS; FILL+1.
//   WRITE & FULL -> data dropped, OVERFLOW<=1 (cleared only by reset or CLEAR).
//  READ sync: 2-flop synchroniser + rising-edge detect -> rd_evt (1 cycle); READ edge to
//   rd_evt = 3 coreClock cycles. READ high-time must be >= 2 coreClock cycles.
//  Word order per pair: idx0=RE[31:16], idx1=RE[15:0], idx2=IM[31:16], idx3=IM[15:0].
//  rd_evt & !EMPTY: idx+1; on idx==3 -> idx=0, rptr+1 mod DEPTH_PAIRS, FILL-1.
//   rd_evt & EMPTY: ignored; no pointer change, no flag.
//  DOUT is registered: word of mem[rptr] at idx, valid 1 cycle after a pointer/idx change or
//   a write into an empty buffer. When EMPTY, DOUT holds its last value.
//  Simultaneous push and pair-pop in the same cycle: FILL unchanged. Push to a full buffer in
//   the same cycle as a pair-pop is accepted (FULL evaluated before the pop) -> no OVERFLOW.
//  Frame FSM:
//   IDLE : READY2READ=0; if FILL >= FRAME_PAIRS -> ARMED, words_left = 4*FRAME_PAIRS.
//   ARMED: READY2READ=1; each accepted rd_evt decrements words_left; at 0 -> IDLE
//          (READY2READ low >= 1 cycle between frames, even if the next frame is stored).
//  CLEAR (sync, priority over WRITE/rd_evt in the same cycle): pointers, idx, FILL=0,
//   OVERFLOW=0, FSM=IDLE; DOUT=0. Memory contents are not cleared.
//  Mid-frame reset or CLEAR: partial frame discarded; host sees READY2READ fall.
// STRUCTURE
//  usd_pkg (shared with Demodulate/CommunicationLayer): RegBusWidth, IQ word-index constants
//   (IDX_RE_HI..IDX_IM_LO), frame FSM state encoding.
//  Sub-module read_strobe_sync: 2-flop sync + rising-edge detect (reusable for other SPI strobes).
//  Memory: single simple dual-port array, 1 write port and 1 registered read port (maps to EBR).
// TESTING
//  Reset: ENABLE low mid-traffic -> next cycle all outputs at reset values, EMPTY=1, FILL=0.
//  Order: push RE=0x12345678, IM=0x9ABCDEF0; 4 READ edges -> DOUT 1234,5678,9ABC,DEF0; EMPTY.
//  Frame: FRAME_PAIRS=4; push 3 -> READY2READ=0; 4th -> READY2READ=1 after 1 cycle; 16 reads -> 0.
//  Overflow: DEPTH=8; push 9 -> FULL=1, OVERFLOW=1, 9th dropped; CLEAR -> EMPTY=1, OVERFLOW=0.
//  Concurrency: full buffer, WRITE in the cycle of idx3 pop -> accepted, FILL=8, no OVERFLOW.
//  Wrap/empty read: 3 x (fill 8, drain 8) -> data intact across wrap; READ while EMPTY ignored.

Source files
------------

// File: rtl/usd_pkg.sv
// Shared definitions for the Demodulate / frame buffer / CommunicationLayer path:
// register-bus word width, I/Q word-index constants and the frame FSM encoding.
package usd_pkg;

    localparam int unsigned RegBusWidth = 16;

    // Word order within one stored I/Q pair
    localparam logic [1:0] IDX_RE_HI = 2'd0;
    localparam logic [1:0] IDX_RE_LO = 2'd1;
    localparam logic [1:0] IDX_IM_HI = 2'd2;
    localparam logic [1:0] IDX_IM_LO = 2'd3;

    typedef enum logic {
        FRAME_IDLE  = 1'b0,
        FRAME_ARMED = 1'b1
    } frame_state_t;

    // Pick one 16-bit word out of a {RE, IM} pair
    function automatic logic [RegBusWidth-1:0] iq_word_sel(
        input logic [63:0] pair,
        input logic [1:0]  idx
    );
        logic [RegBusWidth-1:0] word;
        case (idx)
            IDX_RE_HI: word = pair[63:48];
            IDX_RE_LO: word = pair[47:32];
            IDX_IM_HI: word = pair[31:16];
            default:   word = pair[15:0];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/read_strobe_sync.sv
// Brings an asynchronous strobe into the clk domain (2-flop synchroniser) and
// emits a registered one-cycle pulse on its rising edge. Input edge to pulse
// is 3 clk cycles; the strobe must stay high for at least 2 clk cycles.
module read_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_async,
    output logic strobe_evt
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise, keep the previous synchronised level, register the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            prev_q     <= 1'b0;
            strobe_evt <= 1'b0;
        end else begin
            meta_q     <= strobe_async;
            sync_q     <= meta_q;
            prev_q     <= sync_q;
            strobe_evt <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/iq_frame_buffer.sv
// I/Q frame buffer: stores 64-bit {RE, IM} pairs written by the demodulator and
// serves them as 16-bit words to the SPI layer, one word per READ strobe.
// READY2READ is raised once a whole frame of pairs is stored and held until the
// host has read that frame's words.
module iq_frame_buffer
    import usd_pkg::*;
#(
    parameter int unsigned DEPTH_PAIRS = 256,
    parameter int unsigned FRAME_PAIRS = 64,
    parameter int unsigned WORD_W      = RegBusWidth
) (
    input  logic                           coreClock,
    input  logic                           ENABLE,
    input  logic                           WRITE,
    input  logic [31:0]                    RE_IN,
    input  logic [31:0]                    IM_IN,
    input  logic                           READ,
    input  logic                           CLEAR,
    output logic [WORD_W-1:0]              DOUT,
    output logic                           READY2READ,
    output logic                           FULL,
    output logic                           EMPTY,
    output logic                           OVERFLOW,
    output logic [$clog2(DEPTH_PAIRS):0]   FILL
);

    localparam int unsigned AW  = $clog2(DEPTH_PAIRS);
    localparam int unsigned FW  = AW + 1;
    localparam int unsigned WLW = $clog2(4 * FRAME_PAIRS) + 1;

    logic [63:0]       mem [DEPTH_PAIRS];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [1:0]        idx;
    logic [FW-1:0]     fill;
    logic              overflow_q;
    logic [WORD_W-1:0] dout_q;

    logic rd_evt;
    logic rd_accept;
    logic pair_pop;
    logic push;
    logic drop;
    logic full;
    logic empty;

    frame_state_t   state;
    frame_state_t   state_nxt;
    logic [WLW-1:0] words_left;
    logic [WLW-1:0] words_left_nxt;
    logic           ready_nxt;

    read_strobe_sync u_read_sync (
        .clk          (coreClock),
        .rst_n        (ENABLE),
        .strobe_async (READ),
        .strobe_evt   (rd_evt)
    );

    assign full  = (fill == FW'(DEPTH_PAIRS));
    assign empty = (fill == '0);

    // A pair pop frees its slot in the same cycle, so a push into a full
    // buffer is accepted when it coincides with the last-word pop.
    assign rd_accept = rd_evt & ~empty;
    assign pair_pop  = rd_accept & (idx == IDX_IM_LO);
    assign push      = WRITE & (~full | pair_pop);
    assign drop      = WRITE & full & ~pair_pop;

    // Pair storage: one write port; CLEAR suppresses a coincident write
    always_ff @(posedge coreClock) begin
        if (push && !CLEAR) begin
            mem[wptr] <= {RE_IN, IM_IN};
        end
    end

    // Pointers, word index, fill level and sticky overflow
    always_ff @(posedge coreClock or negedge ENABLE) begin
        if (!ENABLE) begin
            wptr       <= '0;
            rptr       <= '0;
            idx        <= IDX_RE_HI;
            fill       <= '0;
            overflow_q <= 1'b0;
        end else if (CLEAR) begin
            wptr       <= '0;
            rptr       <= '0;
            idx        <= IDX_RE_HI;
            fill       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_accept) begin
                idx <= idx + 2'd1;
            end
            if (pair_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pair_pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Registered read port: current word of the head pair, held while empty
    always_ff @(posedge coreClock or negedge ENABLE) begin
        if (!ENABLE) begin
            dout_q <= '0;
        end else if (CLEAR) begin
            dout_q <= '0;
        end else if (!empty) begin
            dout_q <= WORD_W'(iq_word_sel(mem[rptr], idx));
        end
    end

    // Frame FSM state register
    always_ff @(posedge coreClock or negedge ENABLE) begin
        if (!ENABLE) begin
            state      <= FRAME_IDLE;
            words_left <= '0;
        end else if (CLEAR) begin
            state      <= FRAME_IDLE;
            words_left <= '0;
        end else begin
            state      <= state_nxt;
            words_left <= words_left_nxt;
        end
    end

    // Frame FSM next state: arm on a stored frame, disarm after its last word
    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        ready_nxt      = 1'b0;
        case (state)
            FRAME_IDLE: begin
                if (fill >= FW'(FRAME_PAIRS)) begin
                    state_nxt      = FRAME_ARMED;
                    words_left_nxt = WLW'(4 * FRAME_PAIRS);
                end
            end
            FRAME_ARMED: begin
                ready_nxt = 1'b1;
                if (rd_accept) begin
                    words_left_nxt = words_left - WLW'(1);
                    if (words_left == WLW'(1)) begin
                        state_nxt = FRAME_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = FRAME_IDLE;
            end
        endcase
    end

    assign DOUT       = dout_q;
    assign READY2READ = ready_nxt;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign OVERFLOW   = overflow_q;
    assign FILL       = fill;

endmodule

// File: tb/tb_iq_frame_buffer.sv
// Self-checking bench for iq_frame_buffer (DEPTH_PAIRS=8, FRAME_PAIRS=4).
// Pushed pairs go into a scoreboard queue; each host word read is compared
// against the head pair of that queue.
module tb_iq_frame_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FRAME = 4;

    logic        coreClock = 1'b0;
    logic        ENABLE;
    logic        WRITE;
    logic [31:0] RE_IN;
    logic [31:0] IM_IN;
    logic        READ;
    logic        CLEAR;
    logic [15:0] DOUT;
    logic        READY2READ;
    logic        FULL;
    logic        EMPTY;
    logic        OVERFLOW;
    logic [3:0]  FILL;

    always #5 coreClock = ~coreClock;

    iq_frame_buffer #(
        .DEPTH_PAIRS (DEPTH),
        .FRAME_PAIRS (FRAME),
        .WORD_W      (16)
    ) dut (
        .coreClock  (coreClock),
        .ENABLE     (ENABLE),
        .WRITE      (WRITE),
        .RE_IN      (RE_IN),
        .IM_IN      (IM_IN),
        .READ       (READ),
        .CLEAR      (CLEAR),
        .DOUT       (DOUT),
        .READY2READ (READY2READ),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .OVERFLOW   (OVERFLOW),
        .FILL       (FILL)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    int unsigned exp_idx  = 0;
    logic [15:0] last_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word i of a pair, RE high half first
    function automatic logic [15:0] model_word(input logic [63:0] p, input int unsigned i);
        return p[63 - 16*i -: 16];
    endfunction

    task automatic tick();
        @(posedge coreClock);
        #1;
    endtask

    task automatic push(input logic [31:0] re, input logic [31:0] im);
        RE_IN = re;
        IM_IN = im;
        WRITE = 1'b1;
        tick();
        WRITE = 1'b0;
        tick();
        if (exp_q.size() < DEPTH) exp_q.push_back({re, im});
    endtask

    task automatic pulse_read();
        READ = 1'b1;
        repeat (3) tick();
        READ = 1'b0;
        repeat (4) tick();
    endtask

    // Check the presented word, consume it, and check hold behaviour once empty
    task automatic read_word(input string tag);
        if (exp_q.size() != 0) check(tag, DOUT, model_word(exp_q[0], exp_idx));
        pulse_read();
        if (exp_q.size() != 0) begin
            last_word = model_word(exp_q[0], exp_idx);
            exp_idx++;
            if (exp_idx == 4) begin
                void'(exp_q.pop_front());
                exp_idx = 0;
            end
        end
        if (exp_q.size() == 0) check({tag, "_hold"}, DOUT, last_word);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 4*DEPTH + 4 && exp_q.size() != 0; k++) read_word(tag);
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_idx   = 0;
        last_word = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] re;
        logic [31:0] im;

        ENABLE = 1'b0; WRITE = 1'b0; READ = 1'b0; CLEAR = 1'b0;
        RE_IN = '0; IM_IN = '0;
        repeat (3) tick();
        check("rst_dout",  DOUT, 0);
        check("rst_r2r",   READY2READ, 0);
        check("rst_full",  FULL, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_ovf",   OVERFLOW, 0);
        check("rst_fill",  FILL, 0);
        ENABLE = 1'b1;
        tick();

        // Word order of a single pair
        push(32'h12345678, 32'h9ABCDEF0);
        check("order_fill", FILL, 1);
        check("order_r2r",  READY2READ, 0);
        check("order_w0", DOUT, 16'h1234);
        repeat (4) read_word("order");
        check("order_last",  DOUT, 16'hDEF0);
        check("order_empty", EMPTY, 1);

        // READ while empty is ignored
        read_word("empty_rd");
        check("empty_rd_fill", FILL, 0);
        check("empty_rd_ovf",  OVERFLOW, 0);
        push(32'hCAFE0001, 32'hBEEF0002);
        check("empty_rd_idx", DOUT, 16'hCAFE);
        drain("empty_rd_drain");

        // Frame threshold and READY2READ lifetime
        for (int n = 0; n < 3; n++) begin
            push($urandom(), $urandom());
            tick();
            check("frame_below", READY2READ, 0);
        end
        re = $urandom(); im = $urandom();
        RE_IN = re; IM_IN = im; WRITE = 1'b1;
        tick();
        WRITE = 1'b0;
        check("frame_arm_lat", READY2READ, 0);
        tick();
        check("frame_armed", READY2READ, 1);
        exp_q.push_back({re, im});
        for (int k = 0; k < 16; k++) begin
            read_word("frame_data");
            if (k < 15) check("frame_hold", READY2READ, 1);
            else        check("frame_done", READY2READ, 0);
        end

        // Overflow: ninth push is dropped, flag is sticky until CLEAR
        for (int n = 0; n < 8; n++) push($urandom(), $urandom());
        check("ovf_full", FULL, 1);
        check("ovf_fill", FILL, 8);
        check("ovf_pre",  OVERFLOW, 0);
        push(32'hDEADDEAD, 32'hDEADDEAD);
        check("ovf_set",   OVERFLOW, 1);
        check("ovf_fill9", FILL, 8);
        drain("ovf_data");
        check("ovf_sticky", OVERFLOW, 1);
        push($urandom(), $urandom());
        push($urandom(), $urandom());
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        tick();
        model_clear();
        check("clr_empty", EMPTY, 1);
        check("clr_fill",  FILL, 0);
        check("clr_ovf",   OVERFLOW, 0);
        check("clr_dout",  DOUT, 0);
        check("clr_r2r",   READY2READ, 0);

        // Push into a full buffer in the same cycle as the last-word pop
        for (int n = 0; n < 8; n++) push($urandom(), $urandom());
        repeat (3) read_word("conc_pre");
        check("conc_w3", DOUT, model_word(exp_q[0], 3));
        re = $urandom(); im = $urandom();
        READ = 1'b1;
        repeat (3) tick();
        RE_IN = re; IM_IN = im; WRITE = 1'b1;
        tick();
        WRITE = 1'b0; READ = 1'b0;
        repeat (3) tick();
        void'(exp_q.pop_front());
        exp_idx = 0;
        exp_q.push_back({re, im});
        check("conc_fill", FILL, 8);
        check("conc_full", FULL, 1);
        check("conc_ovf",  OVERFLOW, 0);
        drain("conc_data");

        // Pointer wrap across repeated fill/drain
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 8; n++) push($urandom(), $urandom());
            check("wrap_full", FULL, 1);
            drain("wrap_data");
            check("wrap_empty", EMPTY, 1);
        end

        // Reset in the middle of a frame readout
        for (int n = 0; n < 5; n++) push($urandom(), $urandom());
        check("mid_r2r", READY2READ, 1);
        READ = 1'b1;
        tick();
        tick();
        #2 ENABLE = 1'b0;
        READ = 1'b0;
        tick();
        model_clear();
        check("mid_rst_dout",  DOUT, 0);
        check("mid_rst_r2r",   READY2READ, 0);
        check("mid_rst_full",  FULL, 0);
        check("mid_rst_empty", EMPTY, 1);
        check("mid_rst_ovf",   OVERFLOW, 0);
        check("mid_rst_fill",  FILL, 0);
        ENABLE = 1'b1;
        tick();
        push(32'h0BADF00D, 32'h600DCAFE);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
